// File: rtl/mod_inv_bin.sv
// Multi-cycle modular inverse using the binary extended Euclidean algorithm.
// One halving or one subtraction per clock; start/done handshake; flags operands with no inverse.
module mod_inv_bin #(
    parameter int unsigned       WIDTH   = 256,
    parameter logic [WIDTH-1:0]  MODULUS = WIDTH'(256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] input_num,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] inverse
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // x/2 mod MODULUS; odd x is made even by adding the odd modulus (WIDTH+1-bit sum).
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, MODULUS};
        return x[0] ? WIDTH'(s >> 1) : (x >> 1);
    endfunction

    // (a - b) mod MODULUS for a, b in [0, MODULUS); the wrap of a-b is undone by adding MODULUS.
    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        d = a - b;
        return (a >= b) ? d : d + MODULUS;
    endfunction

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        inv_d   = inv_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    u_d     = input_num;
                    v_d     = MODULUS;
                    x1_d    = WIDTH'(1);
                    x2_d    = '0;
                    busy_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if ((u_q == '0) || (u_q >= MODULUS)) begin
                    err_d   = 1'b1;
                    inv_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else if (u_q == WIDTH'(1)) begin
                    inv_d   = WIDTH'(1);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                // Exit test uses the registered operands; u==1 takes precedence over v==1.
                if (u_q == WIDTH'(1)) begin
                    inv_d   = x1_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else if (v_q == WIDTH'(1)) begin
                    inv_d   = x2_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else if ((u_q == '0) || (v_q == '0)) begin
                    err_d   = 1'b1;
                    inv_d   = '0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            inv_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign inverse = inv_q;

endmodule
